// File: rtl/rtp_rx_pkg.sv
// Shared definitions for the RTP audio receive path: parser states and
// fixed RTP header layout.
package rtp_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_DROP
  } parse_state_e;

  localparam int unsigned RTP_HDR_LEN = 12;
  localparam int unsigned SEQ_OFS     = 2;
  localparam int unsigned SSRC_OFS    = 8;

endpackage

// File: rtl/rtp_sample_fifo.sv
// Single-clock sample FIFO with an extra pointer MSB to tell full from empty.
// A write while full is dropped unless a read frees the slot in the same cycle.
module rtp_sample_fifo #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          wr_drop
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [0:DEPTH-1];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          do_wr;
  logic          do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign wr_drop = wr_en && !do_wr;
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, and a reset would block RAM inference.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rtp_audio_depacketizer.sv
// RTP audio receiver: validates the RTP header of each UDP packet, unpacks
// big-endian PCM samples into a jitter FIFO and serves them on wav_rden.
// Optional macro RTP_SSRC_CHECK_EN: drop packets whose SSRC differs from SSRC.
module rtp_audio_depacketizer
  import rtp_rx_pkg::*;
#(
  parameter logic [15:0] RTP_HEADER_PARAM = 16'h8080,
  parameter logic [31:0] SSRC             = 32'h12345678,
  parameter int unsigned FIFO_AW          = 10,
  parameter int unsigned PREFILL          = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               udp_rec_data_valid,
  input  logic [7:0]         udp_rec_rdata,
  input  logic [15:0]        udp_rec_data_length,
  input  logic               wav_rden,
  output logic [15:0]        wav_out_data,
  output logic               playing,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [15:0]        pkt_ok_cnt,
  output logic [15:0]        pkt_drop_cnt,
  output logic [15:0]        seq_gap_cnt,
  output logic [15:0]        underrun_cnt,
  output logic [15:0]        overflow_cnt
);

  parse_state_e state, state_nxt;

  logic [15:0] byte_cnt;
  logic [15:0] len_q;
  logic [7:0]  hi_byte;
  logic [15:0] seq_q;
  logic [15:0] expected_seq;
  logic        seq_seeded;

  logic        byte_bad;
  logic        hdr_done;
  logic        sample_wr;
  logic        pkt_ok_evt;
  logic        pkt_drop_evt;

  logic [15:0] fifo_rd_data;
  logic        fifo_empty;
  logic        fifo_wr_drop;
  logic        play_rd;

`ifdef RTP_SSRC_CHECK_EN
  // Header bytes 8..11 map onto idx 0..3 because the SSRC offset is 4-aligned.
  function automatic logic [7:0] ssrc_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return SSRC[31:24];
      2'd1:    return SSRC[23:16];
      2'd2:    return SSRC[15:8];
      default: return SSRC[7:0];
    endcase
  endfunction
`else
  logic unused_ssrc;
  assign unused_ssrc = ^SSRC;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    byte_bad     = 1'b0;
    hdr_done     = 1'b0;
    sample_wr    = 1'b0;
    pkt_ok_evt   = 1'b0;
    pkt_drop_evt = 1'b0;

    case (state)
      ST_IDLE: begin
        if (udp_rec_data_valid) begin
          if (udp_rec_data_length < 16'(RTP_HDR_LEN) ||
              udp_rec_rdata != RTP_HEADER_PARAM[15:8])
            state_nxt = ST_DROP;
          else
            state_nxt = ST_HDR;
        end
      end

      ST_HDR: begin
        if (!udp_rec_data_valid) begin
          pkt_drop_evt = 1'b1;
          state_nxt    = ST_IDLE;
        end else begin
          if (byte_cnt == 16'd1 && udp_rec_rdata[6:0] != RTP_HEADER_PARAM[6:0])
            byte_bad = 1'b1;
`ifdef RTP_SSRC_CHECK_EN
          if (byte_cnt >= 16'(SSRC_OFS) && udp_rec_rdata != ssrc_byte(byte_cnt[1:0]))
            byte_bad = 1'b1;
`endif
          if (byte_bad) begin
            state_nxt = ST_DROP;
          end else if (byte_cnt == 16'(RTP_HDR_LEN - 1)) begin
            hdr_done  = 1'b1;
            state_nxt = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (!udp_rec_data_valid) begin
          pkt_ok_evt = 1'b1;
          state_nxt  = ST_IDLE;
        end else if (byte_cnt < len_q && byte_cnt[0]) begin
          // The header length is even, so odd byte_cnt is a sample's low byte.
          sample_wr = 1'b1;
        end
      end

      ST_DROP: begin
        if (!udp_rec_data_valid) begin
          pkt_drop_evt = 1'b1;
          state_nxt    = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt     <= '0;
      len_q        <= '0;
      hi_byte      <= '0;
      seq_q        <= '0;
      expected_seq <= '0;
      seq_seeded   <= 1'b0;
    end else begin
      if (state_nxt == ST_IDLE)
        byte_cnt <= '0;
      else if (udp_rec_data_valid && byte_cnt != 16'hFFFF)
        byte_cnt <= byte_cnt + 16'd1;

      if (state == ST_IDLE && udp_rec_data_valid)
        len_q <= udp_rec_data_length;

      if (state == ST_PAYLOAD && udp_rec_data_valid && !byte_cnt[0])
        hi_byte <= udp_rec_rdata;

      if (state == ST_HDR && udp_rec_data_valid) begin
        if (byte_cnt == 16'(SEQ_OFS))     seq_q[15:8] <= udp_rec_rdata;
        if (byte_cnt == 16'(SEQ_OFS + 1)) seq_q[7:0]  <= udp_rec_rdata;
      end

      if (hdr_done) begin
        seq_seeded   <= 1'b1;
        expected_seq <= seq_q + 16'd1;
      end
    end
  end

  assign play_rd = wav_rden && playing;

  rtp_sample_fifo #(
    .AW (FIFO_AW),
    .DW (16)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (sample_wr),
    .wr_data ({hi_byte, udp_rec_rdata}),
    .rd_en   (play_rd),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .level   (fifo_level),
    .wr_drop (fifo_wr_drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wav_out_data <= '0;
      playing      <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (wav_rden)
        wav_out_data <= (playing && !fifo_empty) ? fifo_rd_data : 16'h0000;

      // An underrun forces a fresh prefill before playback resumes.
      if (play_rd && fifo_empty) begin
        playing      <= 1'b0;
        underrun_cnt <= underrun_cnt + 16'd1;
      end else if (32'(fifo_level) >= PREFILL) begin
        playing <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_ok_cnt   <= '0;
      pkt_drop_cnt <= '0;
      seq_gap_cnt  <= '0;
      overflow_cnt <= '0;
    end else begin
      if (pkt_ok_evt)   pkt_ok_cnt   <= pkt_ok_cnt + 16'd1;
      if (pkt_drop_evt) pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
      if (fifo_wr_drop) overflow_cnt <= overflow_cnt + 16'd1;
      if (hdr_done && seq_seeded && seq_q != expected_seq)
        seq_gap_cnt <= seq_gap_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_rtp_audio_depacketizer.sv
// Self-checking bench for rtp_audio_depacketizer: directed and randomized
// packets against a packet-level reference model, plus a small-FIFO instance.
module tb_rtp_audio_depacketizer;

  typedef logic [7:0]  byte_q_t [$];
  typedef logic [15:0] word_q_t [$];

  localparam int A_DEPTH   = 1024;
  localparam int A_PREFILL = 480;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  logic        bus_sel = 1'b0;
  logic        bus_valid = 1'b0;
  logic [7:0]  bus_data = '0;
  logic [15:0] bus_len = '0;
  logic        a_rden = 1'b0;
  logic        b_rden = 1'b0;
  logic        a_valid, b_valid;

  assign a_valid = bus_valid & ~bus_sel;
  assign b_valid = bus_valid & bus_sel;

  logic [15:0] a_wav, a_ok, a_drop, a_gap, a_under, a_over;
  logic        a_playing;
  logic [10:0] a_level;
  logic [15:0] b_wav, b_ok, b_drop, b_gap, b_under, b_over;
  logic        b_playing;
  logic [4:0]  b_level;

  rtp_audio_depacketizer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .udp_rec_data_valid  (a_valid),
    .udp_rec_rdata       (bus_data),
    .udp_rec_data_length (bus_len),
    .wav_rden            (a_rden),
    .wav_out_data        (a_wav),
    .playing             (a_playing),
    .fifo_level          (a_level),
    .pkt_ok_cnt          (a_ok),
    .pkt_drop_cnt        (a_drop),
    .seq_gap_cnt         (a_gap),
    .underrun_cnt        (a_under),
    .overflow_cnt        (a_over)
  );

  rtp_audio_depacketizer #(.FIFO_AW(4), .PREFILL(16)) dut_small (
    .clk                 (clk),
    .rst_n               (rst_n),
    .udp_rec_data_valid  (b_valid),
    .udp_rec_rdata       (bus_data),
    .udp_rec_data_length (bus_len),
    .wav_rden            (b_rden),
    .wav_out_data        (b_wav),
    .playing             (b_playing),
    .fifo_level          (b_level),
    .pkt_ok_cnt          (b_ok),
    .pkt_drop_cnt        (b_drop),
    .seq_gap_cnt         (b_gap),
    .underrun_cnt        (b_under),
    .overflow_cnt        (b_over)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Packet-level reference model of the default instance.
  word_q_t     m_q;
  int          m_ok = 0, m_drop = 0, m_gap = 0, m_under = 0, m_over = 0;
  bit          m_seeded = 0;
  logic [15:0] m_expected = '0;
  bit          m_playing = 0;

  task automatic model_pkt(input byte_q_t p, input logic [15:0] len);
    int n, lim;
    bit bad;
    logic [15:0] seq;
    n = p.size();
    if (n == 0) return;
    bad = (len < 16'd12) || (p[0] != 8'h80) || (n < 12);
    if (!bad) bad = (p[1][6:0] != 7'h00);
`ifdef RTP_SSRC_CHECK_EN
    if (!bad) bad = ({p[8], p[9], p[10], p[11]} != 32'h12345678);
`endif
    if (bad) begin
      m_drop++;
      return;
    end
    seq = {p[2], p[3]};
    if (m_seeded && seq != m_expected) m_gap++;
    m_seeded   = 1;
    m_expected = seq + 16'd1;
    m_ok++;
    lim = (n < int'(len)) ? n : int'(len);
    for (int k = 12; k + 1 < lim; k += 2) begin
      if (m_q.size() < A_DEPTH) m_q.push_back({p[k], p[k+1]});
      else                      m_over++;
    end
    if (m_q.size() >= A_PREFILL) m_playing = 1;
  endtask

  function automatic word_q_t ramp(input int n, input int start);
    word_q_t s;
    for (int i = 0; i < n; i++) s.push_back(16'(start + i));
    return s;
  endfunction

  function automatic word_q_t rand_samples(input int n);
    word_q_t s;
    for (int i = 0; i < n; i++) s.push_back(16'($urandom_range(0, 65535)));
    return s;
  endfunction

  function automatic byte_q_t build_pkt(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [15:0] seq, input logic [31:0] ssrc,
                                        input word_q_t s);
    byte_q_t p;
    p.push_back(b0);
    p.push_back(b1);
    p.push_back(seq[15:8]);
    p.push_back(seq[7:0]);
    for (int i = 0; i < 4; i++) p.push_back(8'($urandom_range(0, 255)));
    for (int i = 3; i >= 0; i--) p.push_back(ssrc[8*i +: 8]);
    foreach (s[i]) begin
      p.push_back(s[i][15:8]);
      p.push_back(s[i][7:0]);
    end
    return p;
  endfunction

  // Drives one packet; rd_at pulses b_rden together with that byte index.
  task automatic send_pkt(input bit sel, input byte_q_t p, input logic [15:0] len, input int rd_at);
    @(negedge clk);
    bus_sel = sel;
    for (int i = 0; i < p.size(); i++) begin
      bus_valid = 1'b1;
      bus_data  = p[i];
      bus_len   = len;
      if (i == rd_at) b_rden = 1'b1;
      @(negedge clk);
      b_rden = 1'b0;
    end
    bus_valid = 1'b0;
    bus_data  = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_a(input string tag);
    check({tag, " level"},    32'(a_level),   32'(m_q.size()));
    check({tag, " playing"},  32'(a_playing), 32'(m_playing));
    check({tag, " ok_cnt"},   32'(a_ok),      32'(16'(m_ok)));
    check({tag, " drop_cnt"}, 32'(a_drop),    32'(16'(m_drop)));
    check({tag, " gap_cnt"},  32'(a_gap),     32'(16'(m_gap)));
    check({tag, " over_cnt"}, 32'(a_over),    32'(16'(m_over)));
  endtask

  task automatic send_a(input string tag, input byte_q_t p, input logic [15:0] len);
    send_pkt(1'b0, p, len, -1);
    model_pkt(p, len);
    check_a(tag);
  endtask

  task automatic read_a(input string tag, input int n);
    logic [15:0] exp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a_rden = 1'b1;
      @(negedge clk);
      a_rden = 1'b0;
      if (!m_playing) begin
        exp = 16'h0000;
      end else if (m_q.size() == 0) begin
        exp = 16'h0000;
        m_under++;
        m_playing = 0;
      end else begin
        exp = m_q.pop_front();
      end
      check({tag, " wav"}, 32'(a_wav), 32'(exp));
    end
    check({tag, " under_cnt"}, 32'(a_under), 32'(16'(m_under)));
    check({tag, " playing"},   32'(a_playing), 32'(m_playing));
    check({tag, " level"},     32'(a_level),   32'(m_q.size()));
  endtask

  initial begin
    byte_q_t     p;
    logic [15:0] seq_r;
    logic [15:0] len;
    int          g0, d0, l0, kind, ns, k;

    repeat (3) @(negedge clk);
    check("rst a wav",   32'(a_wav),   0);
    check("rst a level", 32'(a_level), 0);
    check("rst a play",  32'(a_playing), 0);
    check("rst b level", 32'(b_level), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_a("post-reset");

    // Full 480-sample packet, drained in order, then one read too many.
    p = build_pkt(8'h80, 8'h00, 16'h0000, 32'h12345678, ramp(480, 1));
    send_a("valid", p, 16'(p.size()));
    check("valid level480", 32'(a_level), 480);
    check("valid playing",  32'(a_playing), 1);
    check("valid ok1",      32'(a_ok), 1);
    read_a("drain", 480);
    read_a("underrun", 1);
    check("underrun wav0",  32'(a_wav), 0);
    check("underrun cnt1",  32'(a_under), 1);
    check("underrun stop",  32'(a_playing), 0);

    // Foreign SSRC.
    p = build_pkt(8'h80, 8'h00, 16'h0001, 32'hDEADBEEF, ramp(10, 100));
    send_a("ssrc", p, 16'(p.size()));
`ifdef RTP_SSRC_CHECK_EN
    check("ssrc dropped", 32'(a_drop), 1);
    check("ssrc level0",  32'(a_level), 0);
`else
    check("ssrc accepted", 32'(a_ok), 2);
    check("ssrc level10",  32'(a_level), 10);
`endif

    // Sequence 5, 6, 9 then FFFF -> 0000.
    send_a("seq5", build_pkt(8'h80, 8'h80, 16'd5, 32'h12345678, ramp(2, 1)), 16'd16);
    g0 = int'(a_gap);
    send_a("seq6", build_pkt(8'h80, 8'h00, 16'd6, 32'h12345678, ramp(2, 1)), 16'd16);
    check("seq6 no gap", 32'(a_gap), 32'(g0));
    send_a("seq9", build_pkt(8'h80, 8'h00, 16'd9, 32'h12345678, ramp(2, 1)), 16'd16);
    check("seq9 gap", 32'(a_gap), 32'(g0 + 1));
    send_a("seqFFFF", build_pkt(8'h80, 8'h00, 16'hFFFF, 32'h12345678, ramp(2, 1)), 16'd16);
    g0 = int'(a_gap);
    send_a("seq0000", build_pkt(8'h80, 8'h00, 16'h0000, 32'h12345678, ramp(2, 1)), 16'd16);
    check("seq wrap no gap", 32'(a_gap), 32'(g0));

    // 7-byte runt.
    d0 = int'(a_drop);
    p = build_pkt(8'h80, 8'h00, 16'd1, 32'h12345678, ramp(0, 0));
    while (p.size() > 7) p.delete(p.size() - 1);
    send_a("runt", p, 16'd7);
    check("runt drop", 32'(a_drop), 32'(d0 + 1));

    // 17-byte payload: 8 samples, trailing byte discarded.
    l0 = int'(a_level);
    p = build_pkt(8'h80, 8'h00, 16'd1, 32'h12345678, ramp(8, 16'h0300));
    p.push_back(8'hEE);
    send_a("odd", p, 16'(p.size()));
    check("odd level+8", 32'(a_level), 32'(l0 + 8));

    // Bytes beyond the declared length.
    p = build_pkt(8'h80, 8'h00, 16'd2, 32'h12345678, ramp(10, 16'h0400));
    send_a("trunc", p, 16'd20);

    // Randomized traffic with interleaved read bursts.
    seq_r = 16'd3;
    for (int it = 0; it < 40; it++) begin
      kind  = $urandom_range(0, 9);
      ns    = $urandom_range(0, 40);
      seq_r = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 65535)) : seq_r + 16'd1;
      p = build_pkt(8'h80, {1'($urandom_range(0, 1)), 7'h00}, seq_r, 32'h12345678,
                    rand_samples(ns));
      len = 16'(p.size());
      case (kind)
        0: begin
          p[0] = 8'($urandom_range(0, 255));
          if (p[0] == 8'h80) p[0] = 8'h00;
        end
        1: p[1][6:0] = 7'($urandom_range(1, 127));
        2: p[9] = p[9] ^ 8'h01;
        3: begin
          k = $urandom_range(1, 11);
          while (p.size() > k) p.delete(p.size() - 1);
        end
        4: len = 16'(12 + $urandom_range(0, 2 * ns));
        5: len = 16'($urandom_range(0, 11));
        6: begin
          p.push_back(8'($urandom_range(0, 255)));
          len = 16'(p.size());
        end
        default: ;
      endcase
      send_a("rand", p, len);
      if ($urandom_range(0, 2) == 0) read_a("rand rd", $urandom_range(1, 200));
    end
    read_a("final rd", 64);

    // Small instance: overflow and simultaneous read+write at full.
    p = build_pkt(8'h80, 8'h00, 16'd0, 32'h12345678, ramp(20, 1));
    send_pkt(1'b1, p, 16'(p.size()), -1);
    check("ovf level16",  32'(b_level), 16);
    check("ovf cnt4",     32'(b_over), 4);
    check("ovf playing",  32'(b_playing), 1);
    p = build_pkt(8'h80, 8'h00, 16'd1, 32'h12345678, ramp(1, 16'h0AAA));
    send_pkt(1'b1, p, 16'(p.size()), 13);
    check("rw level16",   32'(b_level), 16);
    check("rw ovf still4", 32'(b_over), 4);
    check("rw head",      32'(b_wav), 16'h0001);
    check("rw ok2",       32'(b_ok), 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
